// File: rtl/hv_i2c_scheduler.sv
// Round-robin scheduler sharing one HV I2C byte-write engine among NREQ requesters.
// Define HV_I2C_WDOG_EN to enable the WAIT watchdog and the err pulses.
module hv_i2c_scheduler #(
  parameter int unsigned NREQ           = 2,
  parameter int unsigned GAP_CYCLES     = 100,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_ins,
  input  logic [8*NREQ-1:0] req_data,
  input  logic              sample_busy,
  output logic              i2c_start,
  output logic [7:0]        i2c_addr,
  output logic [7:0]        i2c_ins,
  output logic [7:0]        i2c_data,
  input  logic              i2c_stop,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic [2:0]        cur_id
);

  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE, S_GAP} state_t;

  state_t            state, state_n;
  logic [2:0]        rr_ptr, rr_n, id_n, winner;
  logic [15:0]       cnt, cnt_n, cnt_inc;
  logic [7:0]        w_addr, w_ins, w_data, addr_n, ins_n, data_n;
  logic [NREQ-1:0]   oh, ack_n, err_n;
  logic              start_n, busy_n;

`ifdef HV_I2C_WDOG_EN
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TIMEOUT_CYCLES);
`endif

  assign cnt_inc = cnt + 16'd1;

  // Winner: lowest set request at or above rr_ptr, else lowest set request overall.
  always_comb begin
    logic       hi_found;
    logic [2:0] hi_id, lo_id;
    hi_found = 1'b0;
    hi_id    = '0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_id = 3'(i);
        if (3'(i) >= rr_ptr) begin
          hi_id    = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_id : lo_id;
  end

  always_comb begin
    w_addr = '0;
    w_ins  = '0;
    w_data = '0;
    oh     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == 3'(i)) begin
        w_addr = req_addr[8*i +: 8];
        w_ins  = req_ins[8*i +: 8];
        w_data = req_data[8*i +: 8];
      end
      oh[i] = (cur_id == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    start_n = 1'b0;
    ack_n   = '0;
    err_n   = '0;
    cnt_n   = cnt;
    rr_n    = rr_ptr;
    id_n    = cur_id;
    addr_n  = i2c_addr;
    ins_n   = i2c_ins;
    data_n  = i2c_data;
    unique case (state)
      S_IDLE: begin
        if ((|req) && !sample_busy) begin
          state_n = S_LAUNCH;
          start_n = 1'b1;
          id_n    = winner;
          addr_n  = w_addr;
          ins_n   = w_ins;
          data_n  = w_data;
          rr_n    = (winner == 3'(NREQ - 1)) ? 3'd0 : winner + 3'd1;
        end
      end
      S_LAUNCH: begin
        state_n = S_WAIT;
        cnt_n   = '0;
      end
      S_WAIT: begin
        cnt_n = cnt_inc;
        if (i2c_stop) begin
          state_n = S_DONE;
          ack_n   = oh;
        end
`ifdef HV_I2C_WDOG_EN
        else if (cnt_inc == TMO) begin
          state_n = S_GAP;
          err_n   = oh;
          cnt_n   = '0;
        end
`endif
      end
      S_DONE: begin
        state_n = S_GAP;
        cnt_n   = '0;
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt_inc;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // Outputs are registered from next-state values so they align with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      i2c_start <= 1'b0;
      i2c_addr  <= '0;
      i2c_ins   <= '0;
      i2c_data  <= '0;
      ack       <= '0;
      err       <= '0;
      busy      <= 1'b0;
      cur_id    <= '0;
      rr_ptr    <= '0;
      cnt       <= '0;
    end else begin
      i2c_start <= start_n;
      i2c_addr  <= addr_n;
      i2c_ins   <= ins_n;
      i2c_data  <= data_n;
      ack       <= ack_n;
      err       <= err_n;
      busy      <= busy_n;
      cur_id    <= id_n;
      rr_ptr    <= rr_n;
      cnt       <= cnt_n;
    end
  end

endmodule

// File: tb/tb_hv_i2c_scheduler.sv
// Self-checking bench for hv_i2c_scheduler: timestamp-based reference model plus directed checks.
module tb_hv_i2c_scheduler;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned GAP   = 100;
  localparam int unsigned TMO   = 1000;
  localparam longint      NEVER = 64'sh3FFF_FFFF_FFFF_FFFF;

  logic              clk         = 1'b0;
  logic              reset_n     = 1'b0;
  logic [NREQ-1:0]   req         = '0;
  logic [8*NREQ-1:0] req_addr    = '0;
  logic [8*NREQ-1:0] req_ins     = '0;
  logic [8*NREQ-1:0] req_data    = '0;
  logic              sample_busy = 1'b0;
  logic              i2c_stop    = 1'b0;
  logic              i2c_start;
  logic [7:0]        i2c_addr, i2c_ins, i2c_data;
  logic [NREQ-1:0]   ack, err;
  logic              busy;
  logic [2:0]        cur_id;

  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc   = 0;

  hv_i2c_scheduler #(.NREQ(NREQ), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_ins(req_ins),
    .req_data(req_data), .sample_busy(sample_busy), .i2c_start(i2c_start),
    .i2c_addr(i2c_addr), .i2c_ins(i2c_ins), .i2c_data(i2c_data), .i2c_stop(i2c_stop),
    .ack(ack), .err(err), .busy(busy), .cur_id(cur_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: transaction timestamps derived from the scheduling rules.
  bit        m_ok = 1'b0;
  bit        tx_active;
  longint    start_cyc, ack_cyc, err_cyc, free_at;
  int        rr, m_id;
  logic [7:0] m_addr, m_ins, m_data;

  task automatic model_clear();
    m_ok      = 1'b1;
    tx_active = 1'b0;
    start_cyc = -1;
    ack_cyc   = -1;
    err_cyc   = -1;
    free_at   = 0;
    rr        = 0;
    m_id      = 0;
    m_addr    = '0;
    m_ins     = '0;
    m_data    = '0;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      model_clear();
    end else begin
      longint c;
      bit     found;
      int     idx;
      c = cyc;
      if (tx_active) begin
        if (c > start_cyc && i2c_stop) begin
          ack_cyc   = c + 1;
          free_at   = c + 2 + GAP;
          tx_active = 1'b0;
        end
`ifdef HV_I2C_WDOG_EN
        else if (c == start_cyc + TMO) begin
          err_cyc   = c + 1;
          free_at   = c + 1 + GAP;
          tx_active = 1'b0;
        end
`endif
      end else if (c >= free_at && req != '0 && !sample_busy) begin
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
          idx = (rr + k) % NREQ;
          if (!found && req[idx]) begin
            found = 1'b1;
            m_id  = idx;
          end
        end
        m_addr    = req_addr[8*m_id +: 8];
        m_ins     = req_ins[8*m_id +: 8];
        m_data    = req_data[8*m_id +: 8];
        rr        = (m_id + 1) % NREQ;
        start_cyc = c + 1;
        free_at   = NEVER;
        tx_active = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [NREQ-1:0] oh;
    if (m_ok) begin
      oh = NREQ'(1) << m_id;
      check("start",  longint'(i2c_start), longint'(cyc == start_cyc));
      check("busy",   longint'(busy),      longint'(start_cyc >= 0 && cyc >= start_cyc && cyc < free_at));
      check("cur_id", longint'(cur_id),    longint'(m_id));
      check("addr",   longint'(i2c_addr),  longint'(m_addr));
      check("ins",    longint'(i2c_ins),   longint'(m_ins));
      check("data",   longint'(i2c_data),  longint'(m_data));
      check("ack",    longint'(ack),       longint'((cyc == ack_cyc) ? oh : '0));
      check("err",    longint'(err),       longint'((cyc == err_cyc) ? oh : '0));
    end
  end

  // what: 0 = start pulse, 1 = ack or err pulse, 2 = busy low
  task automatic wait_for(input int what, input int budget, input string name, output longint at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if ((what == 0 && i2c_start) || (what == 1 && (ack != '0 || err != '0)) ||
          (what == 2 && !busy)) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    if (at < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no event within %0d cycles, expected one", name, budget);
    end
  endtask

  task automatic stop_pulse(output longint m);
    i2c_stop = 1'b1;
    m = cyc;
    @(negedge clk);
    i2c_stop = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    longint n, s, m, a, i, f, e, prev_ack;
    int     seen;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_busy", longint'(busy), 0);
    check("rst_addr", longint'(i2c_addr), 0);
    check("rst_id",   longint'(cur_id), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request with an operand change during WAIT
    req_addr = {8'hA1, 8'h5E};
    req_ins  = {8'hA2, 8'h80};
    req_data = {8'hA3, 8'h08};
    req      = 2'b01;
    n        = cyc;
    wait_for(0, 10, "b_start", s);
    check("b_start_lat", s - n, 1);
    check("b_addr", longint'(i2c_addr), 64'h5E);
    check("b_ins",  longint'(i2c_ins),  64'h80);
    check("b_data", longint'(i2c_data), 64'h08);
    check("b_id",   longint'(cur_id),   0);
    repeat (100) @(negedge clk);
    req_data[7:0] = 8'hFF;
    repeat (100) @(negedge clk);
    stop_pulse(m);
    wait_for(1, 5, "b_ack", a);
    check("b_ack_lat", a - m, 1);
    check("b_ack_val", longint'(ack), 1);
    check("b_data_stable", longint'(i2c_data), 64'h08);
    req           = 2'b00;
    req_data[7:0] = 8'h08;
    wait_for(2, GAP + 10, "b_idle", i);
    check("b_idle_lat", i - m, GAP + 2);

    // Sample-window hold-off, then sample_busy rising mid-WAIT
    sample_busy = 1'b1;
    req         = 2'b10;
    seen        = 0;
    repeat (500) begin
      @(negedge clk);
      if (i2c_start) seen++;
    end
    check("c_no_start", seen, 0);
    sample_busy = 1'b0;
    f           = cyc;
    wait_for(0, 5, "c_start", s);
    check("c_start_lat", s - f, 1);
    check("c_id",   longint'(cur_id),   1);
    check("c_addr", longint'(i2c_addr), 64'hA1);
    repeat (20) @(negedge clk);
    sample_busy = 1'b1;
    repeat (30) @(negedge clk);
    stop_pulse(m);
    wait_for(1, 5, "c_ack", a);
    check("c_ack_lat", a - m, 1);
    check("c_ack_val", longint'(ack), 2);
    req         = 2'b00;
    sample_busy = 1'b0;
    wait_for(2, GAP + 10, "c_idle", i);

    // Reset mid-WAIT, then contention from a fresh round-robin pointer
    req = 2'b01;
    wait_for(0, 5, "d_start", s);
    repeat (10) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("d_rst_busy", longint'(busy), 0);
    check("d_rst_addr", longint'(i2c_addr), 0);
    check("d_rst_data", longint'(i2c_data), 0);
    repeat (3) @(negedge clk);
    reset_n  = 1'b1;
    req      = 2'b11;
    prev_ack = -1;
    for (int g = 0; g < 4; g++) begin
      wait_for(0, GAP + 10, "d_grant_start", s);
      check("d_grant_id", longint'(cur_id), g % 2);
      if (g > 0) check("d_gap", s - prev_ack, GAP + 2);
      repeat (5) @(negedge clk);
      stop_pulse(m);
      wait_for(1, 5, "d_ack", a);
      check("d_ack_val", longint'(ack), (g % 2 == 0) ? 1 : 2);
      prev_ack = a;
    end
    req = 2'b00;
    wait_for(2, GAP + 10, "d_idle", i);

`ifdef HV_I2C_WDOG_EN
    // Watchdog timeout with no stop from the engine
    req = 2'b01;
    wait_for(0, 5, "e_start", s);
    wait_for(1, TMO + 50, "e_err", e);
    check("e_err_lat", e - s, TMO + 1);
    check("e_err_val", longint'(err), 1);
    check("e_no_ack",  longint'(ack), 0);
    req = 2'b00;
    wait_for(2, GAP + 10, "e_idle", i);
    check("e_idle_lat", i - e, GAP);
`else
    // Without the watchdog, WAIT is left only by the engine stop
    req  = 2'b01;
    wait_for(0, 5, "e_start", s);
    seen = 0;
    repeat (TMO + 50) begin
      @(negedge clk);
      if (err != '0 || ack != '0) seen++;
    end
    check("e_no_err", seen, 0);
    check("e_busy",   longint'(busy), 1);
    stop_pulse(m);
    wait_for(1, 5, "e_ack", a);
    check("e_ack_val", longint'(ack), 1);
    req = 2'b00;
    wait_for(2, GAP + 10, "e_idle", i);
`endif

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
